// File: rtl/dct_pkg.sv
// Shared definitions for the down_counter_timer block: FSM state encoding
// and the default counter width.
package dct_pkg;

    // Counter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        DCT_IDLE = 2'd0,
        DCT_RUN  = 2'd1,
        DCT_DONE = 2'd2
    } dct_state_t;

    localparam int DCT_W_DEFAULT = 4;

endpackage

// File: rtl/dct_prescaler.sv
// Prescaler for down_counter_timer: counts enabled cycles 0..PRESC_DIV-1
// and issues a one-cycle tick on the last one. Used only when
// DCT_PRESCALER_EN is defined.
module dct_prescaler #(
    parameter int PRESC_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESC_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count enabled cycles, wrapping on the tick; synchronous clear restarts the period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable W-bit down counter / countdown timer with terminal-count pulse
// and optional auto-reload. Optional feature macro: DCT_PRESCALER_EN
// (count ticks gated by a divide-by-PRESC_DIV prescaler).
module down_counter_timer
    import dct_pkg::*;
#(
    parameter int W         = DCT_W_DEFAULT,
    parameter int PRESC_DIV = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         LD,
    input  logic [W-1:0] D,
    input  logic         En,
    input  logic         AUTO,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         BUSY
);

    localparam logic [W-1:0] ONE = W'(1);

    if (W < 2 || PRESC_DIV < 2) begin : g_bad_param
        $error("down_counter_timer: W and PRESC_DIV must both be >= 2");
    end

    dct_state_t   state, state_n;
    logic [W-1:0] q_n;
    logic [W-1:0] reload, reload_n;
    logic         tc_n;
    logic         tick;

`ifdef DCT_PRESCALER_EN
    dct_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (!CLR || LD),
        .en   (En),
        .tick (tick)
    );
`else
    assign tick = En;
`endif

    assign BUSY = (state == DCT_RUN);

    // Next-state logic: clear beats load beats count/reload; TC is a one-cycle pulse.
    always_comb begin
        state_n  = state;
        q_n      = Q;
        reload_n = reload;
        tc_n     = 1'b0;
        if (!CLR) begin
            state_n = DCT_IDLE;
            q_n     = '0;
        end else if (LD) begin
            q_n      = D;
            reload_n = D;
            state_n  = (D != '0) ? DCT_RUN : DCT_DONE;
        end else if (tick) begin
            case (state)
                DCT_RUN: begin
                    if (Q == ONE) begin
                        q_n     = '0;
                        tc_n    = 1'b1;
                        state_n = DCT_DONE;
                    end else if (Q != '0) begin
                        q_n = Q - ONE;
                    end
                end
                DCT_DONE: begin
                    // A zero reload value would restart a counter that can't decrement.
                    if (AUTO && reload != '0) begin
                        q_n     = reload;
                        state_n = DCT_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, count, reload value and TC registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= DCT_IDLE;
            Q      <= '0;
            reload <= '0;
            TC     <= 1'b0;
        end else begin
            state  <= state_n;
            Q      <= q_n;
            reload <= reload_n;
            TC     <= tc_n;
        end
    end

endmodule
